// File: rtl/core_seq_pkg.sv
// Shared state encoding and core instruction bit map for the systolic core sequencer.
package core_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WLOAD,
    S_WEXEC,
    S_ALOAD,
    S_EXEC,
    S_DRAIN,
    S_SWAP,
    S_DUMP,
    S_DONE
  } state_t;

  localparam int unsigned INST_LOAD    = 0;
  localparam int unsigned INST_EXEC    = 1;
  localparam int unsigned INST_L0RD    = 2;
  localparam int unsigned INST_L0WR    = 3;
  localparam int unsigned INST_OFIFORD = 4;
  localparam int unsigned INST_ACC     = 5;
  localparam int unsigned INST_DUMP    = 6;
  localparam int unsigned INST_RCHIP   = 7;

  // Static instruction bits for a state; L0_WR and OFIFO_RD are dynamic and merged at the top.
  function automatic logic [7:0] inst_for(state_t s, logic rchip, logic acc);
    logic [7:0] v;
    v = '0;
    case (s)
      S_WEXEC: begin
        v[INST_L0RD] = 1'b1;
        v[INST_LOAD] = 1'b1;
      end
      S_EXEC: begin
        v[INST_L0RD] = 1'b1;
        v[INST_EXEC] = 1'b1;
      end
      S_DRAIN: v[INST_ACC]  = acc;
      S_DUMP:  v[INST_DUMP] = 1'b1;
      default: ;
    endcase
    if (s != S_IDLE && s != S_DONE) v[INST_RCHIP] = rchip;
    return v;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Base+offset SRAM read issuer with L0-full stall and a 1-cycle-delayed L0 write strobe.
module seq_addr_gen #(
  parameter int unsigned aw = 11,
  parameter int unsigned cw = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [aw-1:0] base,
  input  logic [cw-1:0] count,
  input  logic          stall,
  output logic          cen,
  output logic [aw-1:0] addr,
  output logic          l0_wr,
  output logic          finished
);

  logic [aw-1:0] next_addr;
  logic [cw-1:0] rem;

  // Finished once all reads are issued and the last one's L0 write is on the wire this cycle.
  assign finished = !load && (rem == '0) && cen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr <= '0;
      rem       <= '0;
      cen       <= 1'b1;
      addr      <= '0;
      l0_wr     <= 1'b0;
    end else begin
      l0_wr <= ~cen;
      if (load) begin
        next_addr <= base;
        rem       <= count;
        cen       <= 1'b1;
      end else if (rem != '0 && !stall) begin
        cen       <= 1'b0;
        addr      <= next_addr;
        next_addr <= next_addr + aw'(1);
        rem       <= rem - cw'(1);
      end else begin
        cen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-pass controller for the 8x8 systolic core: weight/activation load, execute,
// OFIFO drain into ping-pong psum banks, per-pass bank swap and final dump.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned row   = 8,
  parameter int unsigned col   = 8,
  parameter int unsigned aw    = 11,
  parameter int unsigned pw    = 10,
  parameter int unsigned passw = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [passw-1:0] npass,
  input  logic [pw-1:0]    npix,
  input  logic [aw-1:0]    wgt_base,
  input  logic [aw-1:0]    act_base,
  input  logic             l0_full,
  input  logic             ofifo_valid,
  output logic [7:0]       inst,
  output logic             cen_act_wgt,
  output logic             wen_act_wgt,
  output logic [aw-1:0]    addr_act_wgt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = pw + 2;

  state_t           state;
  logic [passw-1:0] pass, npass_r;
  logic [pw-1:0]    npix_r;
  logic [aw-1:0]    wgt_ptr, act_ptr;
  logic [CW-1:0]    cnt;
  logic             rchip, gen_load, gen_finished, l0_wr, ofifo_rd, acc;
  logic [7:0]       inst_r;
  logic [aw-1:0]    gen_base;
  logic [pw-1:0]    gen_count;

  assign acc         = (pass != '0);
  assign gen_base    = (state == S_ALOAD) ? act_ptr : wgt_ptr;
  assign gen_count   = (state == S_ALOAD) ? npix_r : pw'(row);
  assign wen_act_wgt = 1'b1;
  // OFIFO_RD follows ofifo_valid in the same cycle so a toggling valid is read exactly once per beat.
  assign ofifo_rd    = (state == S_DRAIN) && ofifo_valid;

  always_comb begin
    inst               = inst_r;
    inst[INST_L0WR]    = l0_wr;
    inst[INST_OFIFORD] = ofifo_rd;
  end

  seq_addr_gen #(
    .aw(aw),
    .cw(pw)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (gen_load),
    .base    (gen_base),
    .count   (gen_count),
    .stall   (l0_full),
    .cen     (cen_act_wgt),
    .addr    (addr_act_wgt),
    .l0_wr   (l0_wr),
    .finished(gen_finished)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      inst_r   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= '0;
      rchip    <= 1'b0;
      npass_r  <= '0;
      npix_r   <= '0;
      wgt_ptr  <= '0;
      act_ptr  <= '0;
      cnt      <= '0;
      gen_load <= 1'b0;
    end else begin
      done     <= 1'b0;
      gen_load <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          npass_r <= (npass == '0) ? passw'(1) : npass;
          npix_r  <= npix;
          wgt_ptr <= wgt_base;
          act_ptr <= act_base;
          pass    <= '0;
          rchip   <= 1'b0;
          if (npix == '0) begin
            state  <= S_DONE;
            done   <= 1'b1;
            inst_r <= '0;
          end else begin
            state    <= S_WLOAD;
            busy     <= 1'b1;
            gen_load <= 1'b1;
            inst_r   <= inst_for(S_WLOAD, 1'b0, 1'b0);
          end
        end
        S_WLOAD: if (gen_finished) begin
          state  <= S_WEXEC;
          cnt    <= CW'(row - 1);
          inst_r <= inst_for(S_WEXEC, rchip, acc);
        end
        S_WEXEC: if (cnt == '0) begin
          state    <= S_ALOAD;
          gen_load <= 1'b1;
          inst_r   <= inst_for(S_ALOAD, rchip, acc);
        end else begin
          cnt <= cnt - CW'(1);
        end
        S_ALOAD: if (gen_finished) begin
          state  <= S_EXEC;
          cnt    <= CW'(npix_r) + CW'(row + col - 2);
          inst_r <= inst_for(S_EXEC, rchip, acc);
        end
        S_EXEC: if (cnt == '0) begin
          state  <= S_DRAIN;
          cnt    <= CW'(npix_r);
          inst_r <= inst_for(S_DRAIN, rchip, acc);
        end else begin
          cnt <= cnt - CW'(1);
        end
        S_DRAIN: if (ofifo_valid) begin
          if (cnt == CW'(1)) begin
            state  <= S_SWAP;
            inst_r <= inst_for(S_SWAP, rchip, acc);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SWAP: begin
          pass    <= pass + passw'(1);
          rchip   <= ~rchip;
          wgt_ptr <= wgt_ptr + aw'(row);
          act_ptr <= act_ptr + aw'(npix_r);
          if (pass + passw'(1) == npass_r) begin
            state  <= S_DUMP;
            cnt    <= CW'(npix_r);
            inst_r <= inst_for(S_DUMP, ~rchip, 1'b0);
          end else begin
            state    <= S_WLOAD;
            gen_load <= 1'b1;
            inst_r   <= inst_for(S_WLOAD, ~rchip, 1'b0);
          end
        end
        S_DUMP: if (cnt == '0) begin
          state  <= S_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          inst_r <= '0;
        end else begin
          cnt <= cnt - CW'(1);
        end
        S_DONE: begin
          state  <= S_IDLE;
          inst_r <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected reads/drain beats, a monitor pops and compares.
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam int AW = 11, PW = 10, PASSW = 6, ROW = 8, COL = 8;

  logic             clk = 1'b0, reset = 1'b1, start = 1'b0, l0_full = 1'b0, ofifo_valid = 1'b0;
  logic [PASSW-1:0] npass = '0;
  logic [PW-1:0]    npix = '0;
  logic [AW-1:0]    wgt_base = '0, act_base = '0;
  logic [7:0]       inst;
  logic             cen_act_wgt, wen_act_wgt, busy, done;
  logic [AW-1:0]    addr_act_wgt;

  int n_cmp = 0, n_bad = 0;
  int rd_q[$];
  logic [1:0] of_q[$];

  // stimulus-owned job context
  int   cur_npix = 1, job_id = 0, full_mode = 0, of_mode = 0;
  int   exec_base = 0, wexec_base = 0, rd_base = 0;
  logic exp_dump_rchip = 1'b0;

  // monitor-owned counters
  int   rd_seen = 0, l0wr_cnt = 0, exec_cycles = 0, wexec_cycles = 0, dump_cycles = 0, of_cnt = 0, done_cnt = 0;
  logic last_rd_v = 1'b0, m_ld, m_ex, m_of, m_wr;
  logic [AW-1:0] prev_addr = '0;

  // driver-owned
  logic full_at_edge = 1'b0;
  int   stall_left = 0, stalled_job = -1;

  core_sequencer #(.row(ROW), .col(COL), .aw(AW), .pw(PW), .passw(PASSW)) dut (
    .clk(clk), .reset(reset), .start(start), .npass(npass), .npix(npix),
    .wgt_base(wgt_base), .act_base(act_base), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .inst(inst), .cen_act_wgt(cen_act_wgt), .wen_act_wgt(wen_act_wgt),
    .addr_act_wgt(addr_act_wgt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) full_at_edge <= l0_full;

  always @(posedge clk) begin
    #1;
    case (full_mode)
      1: l0_full = ($urandom_range(0, 3) == 0);
      2: begin
        if (stalled_job != job_id && rd_seen - rd_base == 5) begin
          stall_left  = 3;
          stalled_job = job_id;
        end
        l0_full = (stall_left != 0);
        if (stall_left != 0) stall_left--;
      end
      default: l0_full = 1'b0;
    endcase
    ofifo_valid = (of_mode != 0) ? ~ofifo_valid : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (reset) begin
      last_rd_v = 1'b0;
    end else begin
      m_ld = inst[INST_LOAD];
      m_ex = inst[INST_EXEC];
      m_of = inst[INST_OFIFORD];
      m_wr = inst[INST_L0WR];
      chk("excl_load_exec_ofifo", (32'(m_ld) + 32'(m_ex) + 32'(m_of)) <= 32'd1, 1);
      chk("l0wr_lag", m_wr, last_rd_v);
      if (m_wr) l0wr_cnt++;
      if (!cen_act_wgt) begin
        rd_seen++;
        chk("wen_high", wen_act_wgt, 1);
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: read addr %0d, none expected (t=%0t)", addr_act_wgt, $time);
        end else chk("rd_addr", addr_act_wgt, rd_q.pop_front());
      end
      last_rd_v = !cen_act_wgt;
      if (full_at_edge) begin
        chk("stall_cen", cen_act_wgt, 1);
        chk("stall_addr", addr_act_wgt, prev_addr);
      end
      prev_addr = addr_act_wgt;
      if (m_ex) begin
        chk("exec_rchip", inst[INST_RCHIP], ((exec_cycles - exec_base) / (cur_npix + ROW + COL - 1)) % 2);
        exec_cycles++;
      end
      if (m_ld) begin
        chk("wexec_rchip", inst[INST_RCHIP], ((wexec_cycles - wexec_base) / ROW) % 2);
        wexec_cycles++;
      end
      if (inst[INST_DUMP]) begin
        chk("dump_rchip", inst[INST_RCHIP], exp_dump_rchip);
        dump_cycles++;
      end
      if (m_of) begin
        of_cnt++;
        chk("ofifo_rd_needs_valid", ofifo_valid, 1);
        if (of_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ofifo_unexpected: OFIFO_RD with no beat expected (t=%0t)", $time);
        end else chk("drain_acc_rchip", {inst[INST_ACC], inst[INST_RCHIP]}, of_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        chk("done_inst", inst, 0);
      end
    end
  end

  task automatic build_model(input int P, input int N, input int wb, input int ab);
    int pe;
    pe = (P == 0) ? 1 : P;
    rd_q.delete();
    of_q.delete();
    cur_npix       = (N == 0) ? 1 : N;
    exp_dump_rchip = 1'(pe % 2);
    exec_base      = exec_cycles;
    wexec_base     = wexec_cycles;
    rd_base        = rd_seen;
    job_id++;
    if (N != 0)
      for (int p = 0; p < pe; p++) begin
        for (int i = 0; i < ROW; i++) rd_q.push_back((wb + p * ROW + i) % 2048);
        for (int j = 0; j < N; j++) rd_q.push_back((ab + p * N + j) % 2048);
        for (int j = 0; j < N; j++) of_q.push_back({1'(p > 0), 1'(p % 2)});
      end
  endtask

  task automatic run_job(input int P, input int N, input int wb, input int ab,
                         input int fmode, input int omode, input bit poke);
    int pe, c, b_l0, b_dp, b_of, b_dn;
    pe = (P == 0) ? 1 : P;
    @(posedge clk);
    #2;
    full_mode = fmode;
    of_mode   = omode;
    build_model(P, N, wb, ab);
    b_l0 = l0wr_cnt; b_dp = dump_cycles; b_of = of_cnt; b_dn = done_cnt;
    npass = PASSW'(P); npix = PW'(N); wgt_base = AW'(wb); act_base = AW'(ab);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    npass = PASSW'($urandom); npix = PW'($urandom); wgt_base = AW'($urandom); act_base = AW'($urandom);
    chk("busy_on_accept", busy, N != 0);
    chk("done_on_accept", done, N == 0);
    if (poke) begin
      repeat (3) @(posedge clk);
      #2;
      if (busy) begin
        npix = '0; act_base = '0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    end
    c = 0;
    while (done_cnt == b_dn && c < 20000) begin
      @(posedge clk);
      c++;
    end
    chk("done_timeout", done_cnt != b_dn, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("done_pulses", done_cnt - b_dn, 1);
    chk("idle_busy", busy, 0);
    chk("reads_left", rd_q.size(), 0);
    chk("drain_left", of_q.size(), 0);
    chk("l0wr_total", l0wr_cnt - b_l0, (N != 0) ? pe * (ROW + N) : 0);
    chk("exec_cycles", exec_cycles - exec_base, (N != 0) ? pe * (N + ROW + COL - 1) : 0);
    chk("wexec_cycles", wexec_cycles - wexec_base, (N != 0) ? pe * ROW : 0);
    chk("dump_cycles", dump_cycles - b_dp, (N != 0) ? N + 1 : 0);
    chk("ofifo_reads", of_cnt - b_of, (N != 0) ? pe * N : 0);
    rd_q.delete();
    of_q.delete();
  endtask

  initial begin
    int c, P, N;
    @(negedge clk);
    #1;
    chk("rst_inst", inst, 0);
    chk("rst_cen", cen_act_wgt, 1);
    chk("rst_wen", wen_act_wgt, 1);
    chk("rst_addr", addr_act_wgt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    run_job(1, 4, 0, 64, 0, 0, 0);
    run_job(3, 8, 32, 100, 1, 0, 0);
    run_job(1, 4, 16, 300, 2, 0, 0);
    run_job(0, 6, 500, 600, 0, 1, 0);
    run_job(1, 0, 0, 0, 0, 0, 0);
    run_job(1, 16, 2044, 2040, 0, 0, 1);

    // reset in the middle of the activation load
    @(posedge clk);
    #2;
    full_mode = 0;
    build_model(2, 16, 8, 400);
    npass = 6'd2; npix = 10'd16; wgt_base = 11'd8; act_base = 11'd400; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    c = 0;
    while (rd_seen - rd_base < 12 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    chk("t1_reached_aload", rd_seen - rd_base >= 12, 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t1_inst", inst, 0);
    chk("t1_cen", cen_act_wgt, 1);
    chk("t1_busy", busy, 0);
    rd_q.delete();
    of_q.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t1_no_read", cen_act_wgt, 1);
      chk("t1_idle", {busy, done}, 0);
      chk("t1_inst_idle", inst, 0);
    end
    run_job(2, 5, 1000, 1500, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      P = $urandom_range(0, 4);
      N = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      run_job(P, N, $urandom_range(0, 2047), $urandom_range(0, 2047), 1, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
